// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - RV32M funct3 encodings, FSM states and operand decode helpers
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    function automatic logic is_signed_a(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_divider.sv
// rtl/ex_muldiv_unit_divider.sv - iterative restoring divider on unsigned magnitudes, one quotient bit per cycle
module muldiv_divider #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int CW = $clog2(XLEN) + 1;

    logic            active_q, active_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] quo_n, rem_n;

    // quotient/remainder outputs are the combinational result of the current step,
    // so the final values are usable in the same cycle done is raised
    always_comb begin
        trial = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};
        if (!trial[XLEN]) begin
            rem_n = trial[XLEN-1:0];
            quo_n = {quo_q[XLEN-2:0], 1'b1};
        end else begin
            rem_n = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
            quo_n = {quo_q[XLEN-2:0], 1'b0};
        end
    end

    assign done      = active_q && (cnt_q == CW'(1));
    assign quotient  = quo_n;
    assign remainder = rem_n;

    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        if (start) begin
            active_d = 1'b1;
            cnt_d    = CW'(XLEN);
            quo_d    = dividend;
            rem_d    = '0;
            dvs_d    = divisor;
        end else if (abort) begin
            active_d = 1'b0;
        end else if (active_q) begin
            quo_d = quo_n;
            rem_d = rem_n;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative RV32M multiply/divide execute unit with pipeline stall and done pulse
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MUL_UNROLL = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0]   MUL_STEPS = CW'(XLEN / MUL_UNROLL);
    localparam logic [XLEN-1:0] XMIN      = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [2:0]        f3_q, f3_d;
    logic [4:0]        rd_q, rd_d;
    logic              neg_q, neg_d;
    logic              rneg_q, rneg_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [4:0]        rd_out_q, rd_out_d;

    logic              accept, sign_a, sign_b, div_zero, div_ovf, div_start;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [2*XLEN-1:0] mul_next, prod;
    logic [XLEN:0]     psum;
    logic              div_done;
    logic [XLEN-1:0]   div_quo, div_rem, quo_fix, rem_fix;

    assign accept    = start && !flush && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign sign_a    = is_signed_a(funct3) && op_a[XLEN-1];
    assign sign_b    = is_signed_b(funct3) && op_b[XLEN-1];
    assign mag_a     = sign_a ? -op_a : op_a;
    assign mag_b     = sign_b ? -op_b : op_b;
    assign div_zero  = (op_b == '0);
    assign div_ovf   = is_signed_a(funct3) && (op_a == XMIN) && (op_b == '1);
    assign div_start = accept && is_div(funct3) && !div_zero && !div_ovf;

    // shift-add: low half starts as the multiplier and drains out as the product grows in
    always_comb begin
        mul_next = acc_q;
        psum     = '0;
        for (int i = 0; i < MUL_UNROLL; i++) begin
            psum     = {1'b0, mul_next[2*XLEN-1:XLEN]} + (mul_next[0] ? {1'b0, mcand_q} : '0);
            mul_next = {psum, mul_next[XLEN-1:1]};
        end
        prod = neg_q ? -mul_next : mul_next;
    end

    muldiv_divider #(.XLEN(XLEN)) u_divider (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .abort     (flush),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    assign quo_fix = neg_q  ? -div_quo : div_quo;
    assign rem_fix = rneg_q ? -div_rem : div_rem;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        f3_d     = f3_q;
        rd_d     = rd_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        rd_out_d = rd_out_q;
        case (state_q)
            S_MUL: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = mul_next;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d  = S_DONE;
                        result_d = (f3_q == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
                        rd_out_d = rd_q;
                    end
                end
            end
            S_DIV: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (div_done) begin
                    state_d  = S_DONE;
                    result_d = f3_q[1] ? rem_fix : quo_fix;
                    rd_out_d = rd_q;
                end
            end
            default: begin
                if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
                if (accept) begin
                    f3_d    = funct3;
                    rd_d    = rd_in;
                    neg_d   = sign_a ^ sign_b;
                    rneg_d  = sign_a;
                    cnt_d   = is_div(funct3) ? CW'(XLEN) : MUL_STEPS;
                    acc_d   = {{XLEN{1'b0}}, mag_b};
                    mcand_d = mag_a;
                    if (!is_div(funct3)) begin
                        state_d = S_MUL;
                    end else if (div_zero || div_ovf) begin
                        // special cases resolve at acceptance and skip the iterative core
                        state_d  = S_DONE;
                        rd_out_d = rd_in;
                        if (div_zero) begin
                            result_d = funct3[1] ? op_a : '1;
                        end else begin
                            result_d = funct3[1] ? '0 : XMIN;
                        end
                    end else begin
                        state_d = S_DIV;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            f3_q     <= '0;
            rd_q     <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            f3_q     <= f3_d;
            rd_q     <= rd_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
        end
    end

    assign busy   = (state_q == S_MUL) || (state_q == S_DIV);
    assign stall  = busy || accept;
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign rd_out = rd_out_q;

endmodule
